// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects the DE1 buttons into one-cycle strobes,
// and generates the gravity tick. Define AUTO_REPEAT_EN to add auto-repeat on held left/right buttons.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GRAVITY_CYCLES  = 25000000,
  parameter int DAS_CYCLES      = 8000000,
  parameter int ARR_CYCLES      = 2500000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_left,
  input  logic key_right,
  input  logic key_rot,
  input  logic soft_drop,
  output logic left_final,
  output logic right_final,
  output logic rot_final,
  output logic tick_gravity
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GW = (GRAVITY_CYCLES > 1) ? $clog2(GRAVITY_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST        = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GRAV_LAST      = GW'(GRAVITY_CYCLES - 1);
  localparam logic [GW-1:0] GRAV_LAST_SOFT = GW'((GRAVITY_CYCLES >> 3) - 1);

  // Button vectors are ordered {rot, right, left}
  logic [2:0]    r_btn_meta;
  logic [2:0]    r_btn_sync;
  logic          r_sd_meta;
  logic          r_sd_sync;
  logic [2:0]    w_stable;
  logic [2:0]    r_stable_d;
  logic [2:0]    w_rise;
  logic [1:0]    w_rep;
  logic          w_ev_left;
  logic          w_ev_right;
  logic [GW-1:0] r_grav_cnt;
  logic [GW-1:0] w_grav_last;
  logic          r_left;
  logic          r_right;
  logic          r_rot;
  logic          r_tick;

  // Buttons are inverted on entry so that 1 means pressed and the reset value means released
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 3'b000;
      r_btn_sync <= 3'b000;
      r_sd_meta  <= 1'b0;
      r_sd_sync  <= 1'b0;
    end else begin
      r_btn_meta <= ~{key_rot, key_right, key_left};
      r_btn_sync <= r_btn_meta;
      r_sd_meta  <= soft_drop;
      r_sd_sync  <= r_sd_meta;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_stb;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
      end else if (r_btn_sync[g] == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_stb <= r_btn_sync[g];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end

    assign w_stable[g] = r_stb;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_stable_d <= 3'b000;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  assign w_rise = w_stable & ~r_stable_d;

`ifdef AUTO_REPEAT_EN
  // state     | meaning
  // AR_IDLE   | button released, or both directions held; waiting for a press
  // AR_DELAY  | held since the press; counting the initial auto-repeat delay
  // AR_REPEAT | still held; one strobe every ARR_CYCLES
  localparam int RN = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RW = (RN > 1) ? $clog2(RN) : 1;
  localparam logic [RW-1:0] DAS_LAST = RW'(DAS_CYCLES - 1);
  localparam logic [RW-1:0] ARR_LAST = RW'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {
    AR_IDLE,
    AR_DELAY,
    AR_REPEAT
  } ar_state_t;

  logic w_both_held;
  assign w_both_held = w_stable[0] & w_stable[1];

  for (genvar g = 0; g < 2; g++) begin : g_ar
    ar_state_t     r_state;
    ar_state_t     w_state_nxt;
    logic [RW-1:0] r_cnt;
    logic [RW-1:0] w_cnt_nxt;
    logic          w_pulse;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_state <= AR_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Release or a left+right hold cancels repeating in the same cycle it is seen
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse     = 1'b0;
      if (!w_stable[g] || w_both_held) begin
        w_state_nxt = AR_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          AR_IDLE: begin
            if (w_rise[g]) begin
              w_state_nxt = AR_DELAY;
              w_cnt_nxt   = '0;
            end
          end
          AR_DELAY: begin
            if (r_cnt == DAS_LAST) begin
              w_pulse     = 1'b1;
              w_state_nxt = AR_REPEAT;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + RW'(1);
            end
          end
          AR_REPEAT: begin
            if (r_cnt == ARR_LAST) begin
              w_pulse   = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = r_cnt + RW'(1);
            end
          end
          default: begin
            w_state_nxt = AR_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign w_rep[g] = w_pulse;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{DAS_CYCLES, ARR_CYCLES};
  assign w_rep        = 2'b00;
`endif

  assign w_ev_left  = w_rise[0] | w_rep[0];
  assign w_ev_right = w_rise[1] | w_rep[1];

  // >= rather than == so a soft-drop limit below the current count ticks immediately
  assign w_grav_last = r_sd_sync ? GRAV_LAST_SOFT : GRAV_LAST;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_grav_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_grav_cnt >= w_grav_last) begin
      r_grav_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_grav_cnt <= r_grav_cnt + GW'(1);
      r_tick     <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_left  <= w_ev_left & ~w_ev_right;
      r_right <= w_ev_right & ~w_ev_left;
      r_rot   <= w_rise[2];
    end
  end

  assign left_final   = r_left;
  assign right_final  = r_right;
  assign rot_final    = r_rot;
  assign tick_gravity = r_tick;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random stimulus against a
// cycle-level behavioural model. Honours AUTO_REPEAT_EN the same way the design does.
module tb_input_conditioner;
  localparam int DEB  = 4;
  localparam int GRAV = 16;
  localparam int DAS  = 8;
  localparam int ARR  = 3;
  localparam int HMAX = 8192;

  logic CLOCK_50 = 1'b0;
  logic resetn;
  logic key_left;
  logic key_right;
  logic key_rot;
  logic soft_drop;
  logic left_final;
  logic right_final;
  logic rot_final;
  logic tick_gravity;

  always #5 CLOCK_50 = ~CLOCK_50;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .GRAVITY_CYCLES (GRAV),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_rot     (key_rot),
    .soft_drop   (soft_drop),
    .left_final  (left_final),
    .right_final (right_final),
    .rot_final   (rot_final),
    .tick_gravity(tick_gravity)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: per-edge history of pressed levels {0:left,1:right,2:rot,3:soft_drop}
  bit m_raw [4][HMAX];
  int m_t;
  bit m_stab   [3];
  bit m_stab_p [3];
  int m_gcnt;
  bit m_arm    [2];
  int m_start  [2];
  bit e_left, e_right, e_rot, e_tick;
  int obs_left, obs_right, obs_rot, obs_tick;

  // Level seen by the debounce/gravity logic at edge k: input two edges earlier, 0 just after reset
  function automatic bit sync_in(input int b, input int k);
    return (k >= 3) ? m_raw[b][k-2] : 1'b0;
  endfunction

  function automatic bit rep_due(input int d);
    return (d >= DAS) && (((d - DAS) % ARR) == 0);
  endfunction

  task automatic model_reset();
    m_t  = 0;
    m_gcnt = 0;
    for (int b = 0; b < 3; b++) begin
      m_stab[b]   = 1'b0;
      m_stab_p[b] = 1'b0;
    end
    for (int b = 0; b < 2; b++) begin
      m_arm[b]   = 1'b0;
      m_start[b] = 0;
    end
    e_left = 1'b0; e_right = 1'b0; e_rot = 1'b0; e_tick = 1'b0;
  endtask

  task automatic model_edge();
    bit rise [3];
    bit rep  [2];
    bit both, ev_l, ev_r, all_diff, sd;
    int t, lim;
    m_t++;
    t = m_t;
    m_raw[0][t] = ~key_left;
    m_raw[1][t] = ~key_right;
    m_raw[2][t] = ~key_rot;
    m_raw[3][t] = soft_drop;
    for (int b = 0; b < 3; b++) rise[b] = m_stab[b] & ~m_stab_p[b];
    both = m_stab[0] & m_stab[1];
    rep[0] = 1'b0;
    rep[1] = 1'b0;
`ifdef AUTO_REPEAT_EN
    for (int b = 0; b < 2; b++) begin
      if (m_arm[b] && m_stab[b] && !both && rep_due(t - m_start[b])) rep[b] = 1'b1;
      if (!m_stab[b] || both) m_arm[b] = 1'b0;
      else if (rise[b]) begin
        m_arm[b]   = 1'b1;
        m_start[b] = t;
      end
    end
`endif
    ev_l    = rise[0] | rep[0];
    ev_r    = rise[1] | rep[1];
    e_left  = ev_l & ~ev_r;
    e_right = ev_r & ~ev_l;
    e_rot   = rise[2];
    // A level is accepted once DEB consecutive samples all disagree with the current one
    for (int b = 0; b < 3; b++) begin
      m_stab_p[b] = m_stab[b];
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if ((t - j) < 1 || sync_in(b, t - j) == m_stab[b]) all_diff = 1'b0;
      if (all_diff) m_stab[b] = ~m_stab[b];
    end
    sd  = sync_in(3, t);
    lim = sd ? (GRAV >> 3) : GRAV;
    if (m_gcnt >= lim - 1) begin
      e_tick = 1'b1;
      m_gcnt = 0;
    end else begin
      e_tick = 1'b0;
      m_gcnt++;
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    check_val("left_final", left_final, e_left);
    check_val("right_final", right_final, e_right);
    check_val("rot_final", rot_final, e_rot);
    check_val("tick_gravity", tick_gravity, e_tick);
    obs_left  += int'(left_final);
    obs_right += int'(right_final);
    obs_rot   += int'(rot_final);
    obs_tick  += int'(tick_gravity);
  endtask

  task automatic apply_reset(input int n);
    resetn = 1'b0;
    model_reset();
    #1;
    check_val("async_clear", {left_final, right_final, rot_final, tick_gravity}, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_val("reset_outputs", {left_final, right_final, rot_final, tick_gravity}, 0);
    end
    resetn = 1'b1;
  endtask

  initial begin
    int first, second, cnt, base, base_r, exp_r, c;
    int dur [4];
    obs_left = 0; obs_right = 0; obs_rot = 0; obs_tick = 0;
    key_left = 1'b1; key_right = 1'b1; key_rot = 1'b1; soft_drop = 1'b0; resetn = 1'b0;
    model_reset();
    @(negedge CLOCK_50);

    // Reset and gravity cadence
    apply_reset(5);
    first = -1; cnt = 0; base = obs_left + obs_right + obs_rot;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (tick_gravity) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check_val("grav_first", first, 16);
    check_val("grav_count", cnt, 3);
    check_val("grav_no_buttons", obs_left + obs_right + obs_rot - base, 0);

    // Bounce on left, then a clean hold short enough that no repeat is due
    base = obs_left;
    for (int i = 0; i < 10; i++) begin
      key_left = ~key_left;
      step();
      step();
    end
    check_val("bounce_none", obs_left - base, 0);
    key_left = 1'b0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (left_final && first < 0) first = i;
    end
    check_val("bounce_latency", first, 7);
    key_left = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check_val("bounce_count", obs_left - base, 1);

    // Left+right conflict, then an independent rotate
    base = obs_left; base_r = obs_right;
    key_left = 1'b0; key_right = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check_val("conflict_left", obs_left - base, 0);
    check_val("conflict_right", obs_right - base_r, 0);
    base = obs_rot; first = -1;
    key_rot = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rot_final && first < 0) first = i;
    end
    check_val("rot_latency", first, 7);
    check_val("rot_count", obs_rot - base, 1);
    key_left = 1'b1; key_right = 1'b1; key_rot = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Soft drop engaged with the gravity count at 10
    c = 0;
    while (m_gcnt != 10 && c < 40) begin
      step();
      c++;
    end
    soft_drop = 1'b1; first = -1; second = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tick_gravity) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_val("soft_first", first, 3);
    check_val("soft_period", second - first, 2);
    soft_drop = 1'b0; first = -1; second = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick_gravity) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_val("soft_restore", second - first, 16);

    // Hold right for 40 cycles: press strobe at step 7, release seen at step 41, stable drops at step 46
    base = obs_right;
    key_right = 1'b0;
    for (int i = 0; i < 40; i++) step();
    key_right = 1'b1;
    for (int i = 0; i < 15; i++) step();
    exp_r = 1;
`ifdef AUTO_REPEAT_EN
    for (int s = 7 + DAS; s <= 46; s += ARR) exp_r++;
`endif
    check_val("hold_right_count", obs_right - base, exp_r);

    // Reset three cycles before a rotate strobe is due
    base = obs_rot;
    key_rot = 1'b0;
    for (int i = 0; i < 4; i++) step();
    apply_reset(2);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rot_final && first < 0) first = i;
    end
    check_val("midreset_latency", first, 7);
    check_val("midreset_count", obs_rot - base, 1);
    key_rot = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Random key/switch activity with occasional resets
    for (int b = 0; b < 4; b++) dur[b] = $urandom_range(1, 30);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (dur[b] == 0) begin
          case (b)
            0: key_left  = ~key_left;
            1: key_right = ~key_right;
            2: key_rot   = ~key_rot;
            default: soft_drop = ~soft_drop;
          endcase
          dur[b] = (b == 3) ? $urandom_range(1, 60) : $urandom_range(1, 30);
        end else begin
          dur[b]--;
        end
      end
      if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
